pe: RTL and testbench

- Processing element of the row-stationary 3x3 convolution array.
- Holds one 3-tap kernel row (stationary weights) and keeps a 3-sample sliding window over a streamed 8-bit ifmap row.
- Each cycle it computes the 1-D dot product, adds the partial sum arriving from the PE below, and registers the result.
- Three PEs stacked per column form one 3x3 convolution output stream.

---
 rtl/pe_pkg.sv | 21 ++
 rtl/pe_dot3.sv | 40 ++++
 rtl/pe.sv | 67 ++++++
 tb/tb_pe.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_pkg
// Purpose  : Shared widths and types for the row-stationary processing element.
//            data_t       - signed ifmap / weight sample
//            acc_t        - signed partial-sum / output accumulator
//            kernel_row_t - one 3-tap kernel row, [0] = oldest sample tap
// Revision : 1.0 - initial release
// ============================================================================
package pe_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int KSIZE  = 3;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef data_t                    kernel_row_t [0:KSIZE-1];

endpackage : pe_pkg
`default_nettype wire

// File: rtl/pe_dot3.sv
`default_nettype none
// ============================================================================
// Module   : pe_dot3
// Purpose  : Combinational 3-tap signed dot product.
//            dot = w[0]*x_old + w[1]*x_mid + w[2]*x_new
// Ports    : w     in  kernel row (signed 8-bit taps)
//            x_old in  oldest window sample
//            x_mid in  middle window sample
//            x_new in  newest sample (live input)
//            dot   out signed 32-bit sum, wraps modulo 2^32
// Revision : 1.0 - initial release
// ============================================================================
module pe_dot3
    import pe_pkg::*;
(
    input  data_t w [0:KSIZE-1],
    input  data_t x_old,
    input  data_t x_mid,
    input  data_t x_new,
    output acc_t  dot
);

    localparam int c_PROD_W = 2 * DATA_W;

    // Products of two signed 8-bit values always fit in 16 bits.
    logic signed [c_PROD_W-1:0] w_p0;
    logic signed [c_PROD_W-1:0] w_p1;
    logic signed [c_PROD_W-1:0] w_p2;

    assign w_p0 = w[0] * x_old;
    assign w_p1 = w[1] * x_mid;
    assign w_p2 = w[2] * x_new;

    // Explicit sign extension keeps the widths exact for the 32-bit sum.
    assign dot = {{(ACC_W-c_PROD_W){w_p0[c_PROD_W-1]}}, w_p0}
               + {{(ACC_W-c_PROD_W){w_p1[c_PROD_W-1]}}, w_p1}
               + {{(ACC_W-c_PROD_W){w_p2[c_PROD_W-1]}}, w_p2};

endmodule : pe_dot3
`default_nettype wire

// File: rtl/pe.sv
`default_nettype none
// ============================================================================
// Module   : pe
// Purpose  : Row-stationary convolution processing element. Holds one kernel
//            row, keeps a 2-deep sample window plus the live sample, and
//            registers partial_sum_in + dot product each cycle.
// Ports    : clk            in  clock, rising edge
//            rst            in  synchronous active-high reset
//            write_kernel   in  load weights_in into the weight registers
//            ifmap_in       in  streamed ifmap sample
//            partial_sum_in in  partial sum from the PE below
//            weights_in     in  kernel row, [0] oldest tap, [2] newest
//            output_sum     out registered partial sum
// Revision : 1.0 - initial release
// ============================================================================
module pe
    import pe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              write_kernel,
    input  logic [DATA_W-1:0] ifmap_in,
    input  logic [ACC_W-1:0]  partial_sum_in,
    input  data_t             weights_in [0:KSIZE-1],
    output logic [ACC_W-1:0]  output_sum
);

    kernel_row_t r_w;
    data_t       r_x0;   // most recent stored sample
    data_t       r_x1;   // sample before r_x0
    acc_t        r_sum;
    acc_t        w_dot;

    // Dot product uses the pre-edge weights, so a kernel write takes effect
    // on the following edge.
    pe_dot3 u_dot3 (
        .w     (r_w),
        .x_old (r_x1),
        .x_mid (r_x0),
        .x_new (data_t'(ifmap_in)),
        .dot   (w_dot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KSIZE; i++) begin
                r_w[i] <= '0;
            end
            r_x0  <= '0;
            r_x1  <= '0;
            r_sum <= '0;
        end else begin
            if (write_kernel) begin
                for (int i = 0; i < KSIZE; i++) begin
                    r_w[i] <= weights_in[i];
                end
            end
            r_x1  <= r_x0;
            r_x0  <= data_t'(ifmap_in);
            r_sum <= acc_t'(partial_sum_in) + w_dot;
        end
    end

    assign output_sum = r_sum;

endmodule : pe
`default_nettype wire

// File: tb/tb_pe.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe
// Purpose  : Self-checking bench for pe. A reference model computes each
//            expected output when stimulus is driven and pushes it to a
//            scoreboard queue; the value is popped and compared after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe;
    import pe_pkg::*;

    logic              clk;
    logic              rst;
    logic              write_kernel;
    logic [DATA_W-1:0] ifmap_in;
    logic [ACC_W-1:0]  partial_sum_in;
    data_t             weights_in [0:KSIZE-1];
    logic [ACC_W-1:0]  output_sum;

    int checks = 0;
    int errors = 0;

    logic [ACC_W-1:0] sb_q [$];

    // Reference model state
    int               m_w [0:2];
    logic signed [7:0] m_x0;
    logic signed [7:0] m_x1;

    pe dut (
        .clk            (clk),
        .rst            (rst),
        .write_kernel   (write_kernel),
        .ifmap_in       (ifmap_in),
        .partial_sum_in (partial_sum_in),
        .weights_in     (weights_in),
        .output_sum     (output_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, predict with the model, then compare after the edge.
    task automatic step(input bit r, input bit wk,
                        input logic signed [7:0] k0, input logic signed [7:0] k1,
                        input logic signed [7:0] k2,
                        input logic signed [7:0] x, input logic [31:0] ps);
        int d;
        logic [31:0] e;
        rst            = r;
        write_kernel   = wk;
        weights_in[0]  = k0;
        weights_in[1]  = k1;
        weights_in[2]  = k2;
        ifmap_in       = x;
        partial_sum_in = ps;
        if (r) begin
            e = 32'd0;
            m_w[0] = 0; m_w[1] = 0; m_w[2] = 0;
            m_x0 = 8'sd0; m_x1 = 8'sd0;
        end else begin
            d = m_w[0] * int'(m_x1) + m_w[1] * int'(m_x0) + m_w[2] * int'(x);
            e = ps + 32'(d);
            m_x1 = m_x0;
            m_x0 = x;
            if (wk) begin
                m_w[0] = int'(k0); m_w[1] = int'(k1); m_w[2] = int'(k2);
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_val("scoreboard", output_sum, sb_q.pop_front());
    endtask

    task automatic stream(input logic signed [7:0] x, input logic [31:0] ps);
        step(1'b0, 1'b0, 8'sd0, 8'sd0, 8'sd0, x, ps);
    endtask

    task automatic load(input logic signed [7:0] k0, input logic signed [7:0] k1,
                        input logic signed [7:0] k2, input logic [31:0] ps);
        // Load, then one more zero so the window is fully flushed.
        step(1'b0, 1'b1, k0, k1, k2, 8'sd0, ps);
        stream(8'sd0, ps);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; write_kernel = 1'b0; ifmap_in = '0; partial_sum_in = '0;
        for (int i = 0; i < KSIZE; i++) weights_in[i] = '0;
        m_w[0] = 0; m_w[1] = 0; m_w[2] = 0; m_x0 = 8'sd0; m_x1 = 8'sd0;

        // Reset with busy inputs
        step(1'b1, 1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sh55, 32'd7);
        step(1'b1, 1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sh55, 32'd7);
        check_val("reset", output_sum, 32'd0);
        stream(8'sh55, 32'd7);
        check_val("post_reset", output_sum, 32'd7);

        // Basic convolution
        load(8'sd1, 8'sd2, 8'sd3, 32'd0);
        stream(8'sd1, 32'd0);
        stream(8'sd2, 32'd0);
        stream(8'sd3, 32'd0);
        check_val("basic_y0", output_sum, 32'd14);
        stream(8'sd4, 32'd0);
        check_val("basic_y1", output_sum, 32'd20);

        // Partial-sum add
        stream(8'sd0, 32'd100);
        stream(8'sd0, 32'd100);
        stream(8'sd1, 32'd100);
        stream(8'sd2, 32'd100);
        stream(8'sd3, 32'd100);
        check_val("psum_y0", output_sum, 32'd114);
        stream(8'sd4, 32'd100);
        check_val("psum_y1", output_sum, 32'd120);

        // Signed weights and samples
        load(-8'sd1, 8'sd0, 8'sd1, 32'd0);
        stream(8'sd10, 32'd0);
        stream(8'sd20, 32'd0);
        stream(8'sd30, 32'd0);
        check_val("signed_y0", output_sum, 32'd20);
        stream(-8'sd128, 32'd0);
        check_val("signed_y1", output_sum, 32'hFFFFFF6C);

        // Kernel swap mid-stream: old weights on the write edge
        load(8'sd1, 8'sd1, 8'sd1, 32'd0);
        stream(8'sd1, 32'd0);
        stream(8'sd1, 32'd0);
        stream(8'sd1, 32'd0);
        check_val("swap_before", output_sum, 32'd3);
        step(1'b0, 1'b1, 8'sd2, 8'sd2, 8'sd2, 8'sd1, 32'd0);
        check_val("swap_edge_k", output_sum, 32'd3);
        stream(8'sd1, 32'd0);
        check_val("swap_edge_k1", output_sum, 32'd6);
        stream(8'sd1, 32'd0);
        check_val("swap_edge_k2", output_sum, 32'd6);

        // Wrap-around
        load(8'sd0, 8'sd0, 8'sd1, 32'd0);
        stream(8'sd1, 32'hFFFFFFFF);
        check_val("wrap", output_sum, 32'd0);

        // Reset mid-stream clears weights
        step(1'b1, 1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sd9, 32'd5);
        check_val("mid_reset", output_sum, 32'd0);
        stream(8'sd5, 32'd42);
        check_val("no_weights_0", output_sum, 32'd42);
        stream(8'sd7, 32'd42);
        check_val("no_weights_1", output_sum, 32'd42);
        stream(8'sd3, 32'd42);
        check_val("no_weights_2", output_sum, 32'd42);

        // Randomised traffic against the model
        for (int n = 0; n < 200; n++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                 8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pe
`default_nettype wire
